splitt_tree_clk: RTL and testbench

SPLITT_TREE_CLK -- requirements
Module: splitt_tree_clk

---
 rtl/splitt_tree_clk.sv | 118 +++++++++++
 tb/tb_splitt_tree_clk.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/splitt_tree_clk.sv
// Toggle-encoded SFQ clock splitter tree: one input pulse fans out to N_OUT
// outputs after LEVELS*LEVEL_LAT cycles, with a critical-timing guard on input.
module splitt_tree_clk #(
  parameter int N_OUT     = 4,
  parameter int LEVEL_LAT = 1,
  parameter int CT_CYCLES = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic [N_OUT-1:0] en_mask,
  input  logic             err_clr,
  output logic [N_OUT-1:0] q,
  output logic             err,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int LEVELS = $clog2(N_OUT);
  localparam int LAT    = LEVELS * LEVEL_LAT;
  localparam int CT_W   = (CT_CYCLES > 0) ? $clog2(CT_CYCLES + 1) : 1;

  logic            a_q;
  logic            warm;
  logic [CT_W-1:0] ct_cnt;
  logic            pulse_det;
  logic            accept;
  logic            viol;

  // Input edge detector; warm is armed by reset so the first sample after
  // release only primes a_q instead of looking like a pulse.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 1'b0;
      warm <= 1'b1;
    end else begin
      a_q  <= a;
      warm <= 1'b0;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    pulse_det = 1'b0;
    accept    = 1'b0;
    viol      = 1'b0;
    if (!warm && (a != a_q)) begin
      pulse_det = 1'b1;
    end
    if (pulse_det) begin
      if (ct_cnt == '0) accept = 1'b1;
      else              viol   = 1'b1;
    end
  end

  // Window counter: only accepted pulses reopen the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_cnt <= '0;
    end else if (accept) begin
      ct_cnt <= CT_W'(CT_CYCLES);
    end else if (ct_cnt != '0) begin
      ct_cnt <= ct_cnt - CT_W'(1);
    end
  end

  // Error flag and saturating violation counter; a coincident violation wins
  // over err_clr and restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      viol_cnt <= '0;
    end else if (viol) begin
      err <= 1'b1;
      if (err_clr)              viol_cnt <= CNT_W'(1);
      else if (viol_cnt != '1)  viol_cnt <= viol_cnt + CNT_W'(1);
    end else if (err_clr) begin
      err      <= 1'b0;
      viol_cnt <= '0;
    end
  end

  // Splitter levels flattened into an LAT-deep pipeline of valid + mask.
  logic [LAT-1:0]   vld;
  logic [N_OUT-1:0] msk [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // NOTE: the mask payload is not reset; it is only ever consumed alongside
  // its valid bit, which is.
  always_ff @(posedge clk) begin
    if (accept) msk[0] <= en_mask;
    for (int i = 1; i < LAT; i++) begin
      if (vld[i-1]) msk[i] <= msk[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (vld[LAT-1]) begin
      q <= q ^ msk[LAT-1];
    end
  end

endmodule

// File: tb/tb_splitt_tree_clk.sv
// Randomized self-checking bench for splitt_tree_clk against an edge-time
// reference model (accept times, scheduled output toggles).
module tb_splitt_tree_clk;

  localparam int N_OUT     = 4;
  localparam int LEVEL_LAT = 1;
  localparam int CT_CYCLES = 2;
  localparam int CNT_W     = 2;
  localparam int L         = $clog2(N_OUT) * LEVEL_LAT;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a;
  logic [N_OUT-1:0] en_mask;
  logic             err_clr;
  logic [N_OUT-1:0] q;
  logic             err;
  logic [CNT_W-1:0] viol_cnt;

  splitt_tree_clk #(
    .N_OUT(N_OUT), .LEVEL_LAT(LEVEL_LAT), .CT_CYCLES(CT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en_mask(en_mask), .err_clr(err_clr),
    .q(q), .err(err), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, expressed in absolute edge numbers.
  typedef struct { int due; logic [N_OUT-1:0] mask; } toggle_t;
  toggle_t          pend[$];
  int               edge_no;
  int               last_acc;
  bit               has_last;
  bit               m_warm;
  logic             m_aq;
  logic [N_OUT-1:0] m_q;
  bit               m_err;
  int               m_cnt;

  function automatic void model_reset();
    pend.delete();
    has_last = 0;
    m_warm   = 1;
    m_aq     = 1'b0;
    m_q      = '0;
    m_err    = 0;
    m_cnt    = 0;
  endfunction

  function automatic void model_edge(input logic a_v, input logic [N_OUT-1:0] m_v, input logic clr);
    bit pulse, is_viol;
    edge_no++;
    while (pend.size() > 0 && pend[0].due == edge_no) begin
      m_q = m_q ^ pend[0].mask;
      void'(pend.pop_front());
    end
    pulse = !m_warm && (a_v != m_aq);
    m_warm = 0;
    m_aq   = a_v;
    is_viol = 0;
    if (pulse) begin
      is_viol = has_last && (edge_no - last_acc >= 1) && (edge_no - last_acc <= CT_CYCLES);
      if (!is_viol) begin
        last_acc = edge_no;
        has_last = 1;
        pend.push_back('{due: edge_no + L, mask: m_v});
      end
    end
    if (is_viol) begin
      m_err = 1;
      m_cnt = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);
    end else if (clr) begin
      m_err = 0;
      m_cnt = 0;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_q"}, 32'(q), 32'(m_q));
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_cnt"}, 32'(viol_cnt), 32'(m_cnt));
  endtask

  // One clock edge with the given inputs, then compare 1 time unit later.
  task automatic step(input logic a_v, input logic [N_OUT-1:0] m_v, input logic clr, input string tag);
    a = a_v; en_mask = m_v; err_clr = clr;
    @(posedge clk);
    model_edge(a_v, m_v, clr);
    #1;
    compare_all(tag);
  endtask

  // Reset asserted mid-cycle, held over one edge, released mid-cycle.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all({tag, "_in_rst"});
    a = 1'b0;
    @(posedge clk);
    edge_no++;
    #2 rst_n = 1'b1;
  endtask

  task automatic toggle(input logic [N_OUT-1:0] m_v, input logic clr, input string tag);
    step(~a, m_v, clr, tag);
  endtask

  task automatic hold(input int n, input string tag);
    for (int i = 0; i < n; i++) step(a, en_mask, 1'b0, tag);
  endtask

  initial begin
    edge_no = 0;
    model_reset();
    rst_n = 1'b0; a = 1'b0; en_mask = '1; err_clr = 1'b0;
    #1 compare_all("reset");
    repeat (2) @(posedge clk);
    edge_no += 2;
    #2 rst_n = 1'b1;

    // Warm-up with a high: no pulse, then one full-mask pulse.
    step(1'b1, 4'hF, 1'b0, "warm");
    hold(2, "warm_idle");
    toggle(4'hF, 1'b0, "warm_pulse");
    hold(L + 1, "warm_out");
    check("warm_q_final", 32'(q), 32'hF);

    // Pulse at gap 2 (inside window) then gap 3 (after window).
    toggle(4'hF, 1'b0, "ct_first");
    hold(1, "ct_gap");
    toggle(4'hF, 1'b0, "ct_viol");
    hold(4, "ct_settle");
    check("ct_err_set", 32'(err), 32'h1);
    toggle(4'hF, 1'b1, "clr_first");
    hold(2, "exp_gap");
    toggle(4'hF, 1'b0, "exp_second");
    hold(L + 1, "exp_out");

    // Mask captured at acceptance; later changes ignored.
    toggle(4'h5, 1'b0, "mask_acc");
    step(a, 4'hF, 1'b0, "mask_chg");
    hold(L + 1, "mask_out");

    // Reset while a pulse is in flight.
    toggle(4'hF, 1'b0, "rst_acc");
    pulse_reset("rst_flight");
    step(1'b0, 4'hF, 1'b0, "rst_warm");
    hold(L + 2, "rst_after");
    check("rst_q_final", 32'(q), 32'h0);

    // Saturation: five back-to-back violations, then clear plus violation.
    toggle(4'hF, 1'b0, "sat_acc");
    for (int v = 0; v < 5; v++) begin
      toggle(4'hF, 1'b0, "sat_viol");
      hold(CT_CYCLES, "sat_wait");
      toggle(4'hF, 1'b0, "sat_reacc");
    end
    check("sat_cnt", 32'(viol_cnt), 32'(CNT_MAX));
    toggle(4'hF, 1'b1, "sat_clr_viol");
    check("sat_clr_cnt", 32'(viol_cnt), 32'h1);
    check("sat_clr_err", 32'(err), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step(($urandom_range(99) < 45) ? ~a : a, 4'($urandom),
             ($urandom_range(99) < 6), "rnd");
      end
    end
    hold(L + 2, "rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
